// File: rtl/alu_op_sequencer_if.sv
// Handshake and datapath-control bundle between the instruction source,
// the alu_op_sequencer and the ALU result multiplexer / register file.
interface alu_op_sequencer_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [1:0] alu_sel;
  logic [1:0] rs1_addr;
  logic [1:0] rs2_addr;
  logic [1:0] rd_addr;
  logic       rf_we;
  logic [3:0] alu_result;
  logic       zero_flag;
  logic       busy;
  logic [7:0] instr_count;

  // Upstream / environment side
  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_sel, rs1_addr, rs2_addr, rd_addr, rf_we,
           zero_flag, busy, instr_count
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_sel, rs1_addr, rs2_addr, rd_addr, rf_we,
           zero_flag, busy, instr_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: four-state control stage (IDLE/DECODE/EXEC/WB) that
// accepts one 8-bit instruction, drives the ALU select and register-file
// addresses, pulses rf_we in WB and counts retired instructions.
// Optional feature macro: ZERO_FLAG_EN (builds the zero flag register;
// when undefined zero_flag is tied low and alu_result is unused).
module alu_op_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus
);

  // One-hot so every decoded control is a single flop bit (glitch-free rf_we).
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    DECODE = 4'b0010,
    EXEC   = 4'b0100,
    WB     = 4'b1000
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] instr_q;
  logic [7:0] count_q;
  logic       ready_c;
  logic       busy_c;
  logic       we_c;
  logic       accept;

  assign accept = bus.instr_valid && ready_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed four-cycle walk once an instruction is accepted
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = DECODE;
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b1;
    we_c    = 1'b0;
    unique case (state)
      IDLE:    begin ready_c = 1'b1; busy_c = 1'b0; end
      WB:      we_c = 1'b1;
      default: ;
    endcase
  end

  // Instruction register: loaded only on handshake, so fields stay stable until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_q <= '0;
    else if (accept) instr_q <= bus.instr;
  end

  // Retired-instruction counter, advances at the edge closing WB (wraps at 8 bits)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           count_q <= '0;
    else if (state == WB) count_q <= count_q + 8'd1;
  end

`ifdef ZERO_FLAG_EN
  logic zero_q;

  // Zero flag captures the written-back result at the edge closing WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           zero_q <= 1'b0;
    else if (state == WB) zero_q <= (bus.alu_result == 4'b0000);
  end

  assign bus.zero_flag = zero_q;
`else
  logic unused_alu_result;
  assign unused_alu_result = ^bus.alu_result;
  assign bus.zero_flag     = 1'b0;
`endif

  assign bus.instr_ready = ready_c;
  assign bus.busy        = busy_c;
  assign bus.rf_we       = we_c;
  assign bus.alu_sel     = instr_q[7:6];
  assign bus.rd_addr     = instr_q[5:4];
  assign bus.rs1_addr    = instr_q[3:2];
  assign bus.rs2_addr    = instr_q[1:0];
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: expected write-backs are queued
// at each accept and checked when rf_we is seen.
module tb_alu_op_sequencer;

  typedef struct {
    logic [1:0] sel;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] res;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_op_sequencer_if bif ();

  alu_op_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  exp_t       sb[$];
  int         checks;
  int         fails;
  int         pulses;
  logic [7:0] exp_count;
  logic       pend;
  logic       pend_zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: pops on each rf_we pulse, checks flag/count one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      pend = 1'b0;
      checks++;
      if (bif.zero_flag !== pend_zero) begin
        fails++;
        $display("FAIL zero_flag_after_wb: got %b expected %b", bif.zero_flag, pend_zero);
      end
      checks++;
      if (bif.instr_count !== exp_count) begin
        fails++;
        $display("FAIL instr_count_after_wb: got %0d expected %0d", bif.instr_count, exp_count);
      end
    end
    if (rst_n === 1'b1 && bif.rf_we === 1'b1) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rf_we: got rf_we=1 expected no pending instruction");
      end else begin
        e = sb.pop_front();
        if (bif.alu_sel !== e.sel || bif.rd_addr !== e.rd ||
            bif.rs1_addr !== e.rs1 || bif.rs2_addr !== e.rs2) begin
          fails++;
          $display("FAIL wb_fields: got sel=%b rd=%0d rs1=%0d rs2=%0d expected sel=%b rd=%0d rs1=%0d rs2=%0d",
                   bif.alu_sel, bif.rd_addr, bif.rs1_addr, bif.rs2_addr, e.sel, e.rd, e.rs1, e.rs2);
        end
        exp_count = exp_count + 8'd1;
`ifdef ZERO_FLAG_EN
        pend_zero = (e.res == 4'h0);
`else
        pend_zero = 1'b0;
`endif
        pend = 1'b1;
      end
    end
  end

  // Stimulus: called at a negedge; waits (bounded) for ready, performs one handshake,
  // queues the expectation and returns at the DECODE-cycle negedge.
  task automatic send(input logic [7:0] ins, input logic [3:0] res);
    int n = 0;
    exp_t e;
    while (bif.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      fails++;
      $display("FAIL ready_timeout: got instr_ready=%b expected 1", bif.instr_ready);
    end
    bif.instr_valid = 1'b1;
    bif.instr       = ins;
    bif.alu_result  = res;
    @(posedge clk);
    e.sel = ins[7:6]; e.rd = ins[5:4]; e.rs1 = ins[3:2]; e.rs2 = ins[1:0]; e.res = res;
    sb.push_back(e);
    @(negedge clk);
    bif.instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (bif.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL drain_timeout: got instr_ready=%b expected 1", bif.instr_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bif.instr_ready !== 1'b1 || bif.busy !== 1'b0 || bif.rf_we !== 1'b0 ||
        bif.alu_sel !== 2'b00 || bif.instr_count !== 8'd0 || bif.zero_flag !== 1'b0 ||
        bif.rs1_addr !== 2'd0 || bif.rs2_addr !== 2'd0 || bif.rd_addr !== 2'd0) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b busy=%b we=%b sel=%b cnt=%0d z=%b expected 1 0 0 00 0 0",
               bif.instr_ready, bif.busy, bif.rf_we, bif.alu_sel, bif.instr_count, bif.zero_flag);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.instr_ready !== 1'b1 || bif.busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got rdy=%b busy=%b expected 1 0", bif.instr_ready, bif.busy);
    end
  endtask

  task automatic test_single_op();
    send(8'b01_10_01_00, 4'h3);
    checks++;
    if (bif.alu_sel !== 2'b01 || bif.rs1_addr !== 2'd1 || bif.rs2_addr !== 2'd0 ||
        bif.rd_addr !== 2'd2 || bif.busy !== 1'b1 || bif.instr_ready !== 1'b0 || bif.rf_we !== 1'b0) begin
      fails++;
      $display("FAIL single_decode: got sel=%b rs1=%0d rs2=%0d rd=%0d busy=%b rdy=%b we=%b expected 01 1 0 2 1 0 0",
               bif.alu_sel, bif.rs1_addr, bif.rs2_addr, bif.rd_addr, bif.busy, bif.instr_ready, bif.rf_we);
    end
    @(negedge clk);
    checks++;
    if (bif.rf_we !== 1'b0 || bif.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_exec: got we=%b busy=%b expected 0 1", bif.rf_we, bif.busy);
    end
    @(negedge clk);
    checks++;
    if (bif.rf_we !== 1'b1 || bif.rd_addr !== 2'd2) begin
      fails++;
      $display("FAIL single_wb: got we=%b rd=%0d expected 1 2", bif.rf_we, bif.rd_addr);
    end
    @(negedge clk);
    checks++;
    if (bif.instr_count !== 8'd1 || bif.rf_we !== 1'b0 || bif.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_retire: got cnt=%0d we=%b rdy=%b expected 1 0 1",
               bif.instr_count, bif.rf_we, bif.instr_ready);
    end
  endtask

  task automatic test_zero_flag();
    send(8'b00_11_01_10, 4'h0);
    drain();
    checks++;
`ifdef ZERO_FLAG_EN
    if (bif.zero_flag !== 1'b1) begin
`else
    if (bif.zero_flag !== 1'b0) begin
`endif
      fails++;
      $display("FAIL zero_set: got %b", bif.zero_flag);
    end
    send(8'b11_00_10_01, 4'h5);
    drain();
    checks++;
    if (bif.zero_flag !== 1'b0) begin
      fails++;
      $display("FAIL zero_clear: got %b expected 0", bif.zero_flag);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [3];
    time        acc [3];
    int         p0;
    logic [7:0] c0;
    ops[0] = 8'b00_01_10_11;
    ops[1] = 8'b10_10_11_00;
    ops[2] = 8'b11_11_00_01;
    p0 = pulses;
    c0 = bif.instr_count;
    bif.instr_valid = 1'b1;
    bif.alu_result  = 4'h9;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      exp_t e;
      while (bif.instr_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      bif.instr = ops[k];
      @(posedge clk);
      acc[k] = $time;
      e.sel = ops[k][7:6]; e.rd = ops[k][5:4]; e.rs1 = ops[k][3:2]; e.rs2 = ops[k][1:0]; e.res = 4'h9;
      sb.push_back(e);
      @(negedge clk);
      checks++;
      if (bif.alu_sel !== ops[k][7:6]) begin
        fails++;
        $display("FAIL b2b_sel%0d: got %b expected %b", k, bif.alu_sel, ops[k][7:6]);
      end
      if (k == 2) bif.instr_valid = 1'b0;
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (acc[k] - acc[k-1] != 40) begin
        fails++;
        $display("FAIL b2b_spacing%0d: got %0t expected 40", k, acc[k] - acc[k-1]);
      end
    end
    drain();
    checks++;
    if (pulses - p0 != 3 || bif.instr_count !== c0 + 8'd3) begin
      fails++;
      $display("FAIL b2b_totals: got pulses=%0d cnt=%0d expected 3 %0d", pulses - p0, bif.instr_count, c0 + 8'd3);
    end
  endtask

  task automatic test_reset_mid_op();
    int p0;
    p0 = pulses;
    send(8'b01_01_10_11, 4'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bif.instr_ready !== 1'b1 || bif.busy !== 1'b0 || bif.rf_we !== 1'b0 ||
        bif.alu_sel !== 2'b00 || bif.instr_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_op_async: got rdy=%b busy=%b we=%b sel=%b cnt=%0d expected 1 0 0 00 0",
               bif.instr_ready, bif.busy, bif.rf_we, bif.alu_sel, bif.instr_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_count = 8'd0;
    repeat (4) @(negedge clk);
    checks++;
    if (pulses != p0 || bif.instr_count !== 8'd0 || bif.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_op_after: got pulses=%0d cnt=%0d rdy=%b expected %0d 0 1",
               pulses, bif.instr_count, bif.instr_ready, p0);
    end
  endtask

  task automatic test_counter_wrap();
    send(8'b10_01_10_11, 4'h1);
    @(negedge clk);
    bif.instr_valid = 1'b1;
    bif.instr       = 8'b11_00_00_00;
    @(negedge clk);
    checks++;
    if (bif.alu_sel !== 2'b10 || bif.rs2_addr !== 2'd3) begin
      fails++;
      $display("FAIL busy_ignores_instr: got sel=%b rs2=%0d expected 10 3", bif.alu_sel, bif.rs2_addr);
    end
    bif.instr_valid = 1'b0;
    drain();
    for (int i = 1; i < 256; i++) begin
      send(8'($urandom), 4'($urandom_range(0, 15)));
      if (i == 255) begin
        drain();
        checks++;
        if (bif.instr_count !== 8'd0) begin
          fails++;
          $display("FAIL counter_wrap: got %0d expected 0", bif.instr_count);
        end
      end
    end
  endtask

  initial begin
    checks = 0; fails = 0; pulses = 0;
    exp_count = 8'd0; pend = 1'b0; pend_zero = 1'b0;
    bif.instr_valid = 1'b0;
    bif.instr       = 8'h00;
    bif.alu_result  = 4'h0;
    test_reset();
    test_single_op();
    drain();
    test_zero_flag();
    test_back_to_back();
    test_reset_mid_op();
    test_counter_wrap();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle control stage directly upstream of the 4-bit ALU result multiplexer in the mini processor. Accepts one 8-bit instruction per handshake, decodes it and drives the multiplexer's 2-bit select (00 add, 01 sub, 10 and, 11 or), the register-file read/write addresses and the write-enable. It consumes the multiplexer output to maintain an optional zero flag. One instruction is in flight at a time.

## Interface
- No parameters; all widths fixed: 8-bit instruction, 2-bit register addresses, 4-bit data.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  upstream has an instruction on instr
- instr  in  8  [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
- instr_ready  out  1  sequencer can accept; transfer when instr_valid && instr_ready at a rising edge
- alu_sel  out  2  select to the ALU result multiplexer, equals latched op
- rs1_addr  out  2  register-file read port A address
- rs2_addr  out  2  register-file read port B address
- rd_addr  out  2  register-file write address
- rf_we  out  1  register-file write enable, one-cycle pulse
- alu_result  in  4  multiplexer output (selected ALU result)
- zero_flag  out  1  1 when last written-back result was 4'b0000
- busy  out  1  instruction in flight (state != IDLE)
- instr_count  out  8  retired-instruction counter

## Operation
- FSM states: IDLE, DECODE, EXEC, WB. Encoding left to implementer; exactly one state active.
- IDLE: instr_ready=1, busy=0, rf_we=0. On handshake latch instr into internal instruction register, go DECODE. No handshake: stay IDLE.
- DECODE: alu_sel, rs1_addr, rs2_addr, rd_addr driven from latched fields (held stable from here until the next accept). Go EXEC unconditionally.
- EXEC: operands and ALU settle; same outputs held. Go WB.
- WB: rf_we=1 for exactly this cycle, rd_addr valid. At the closing edge: instr_count += 1 (8-bit, 255 wraps to 0), zero_flag updated (see Configuration). Go IDLE.
- instr_ready is 0 in DECODE, EXEC, WB; instr_valid is ignored in those states and instr is not sampled.
- All four op codes legal; no illegal-instruction path.
- rd equal to rs1/rs2 is permitted; read happens in EXEC, write at end of WB, no hazard because only one instruction is in flight.
- Reset values: state IDLE, instr_ready 1, busy 0, rf_we 0, alu_sel 00, rs1_addr/rs2_addr/rd_addr 00, zero_flag 0, instr_count 0, internal instruction register 0.
- Reset asserted mid-instruction: outputs take reset values immediately (asynchronous), in-flight instruction discarded, instr_count not incremented. Deassertion returns to IDLE on the next edge.

## Timing
- Accept at edge N -> DECODE in cycle N+1, EXEC N+2, WB N+3 (rf_we high), IDLE with instr_ready=1 in N+4.
- Throughput: one instruction per 4 cycles; back-to-back valid gives accepts at edges N, N+4, N+8.
- alu_sel, addresses: registered, change only in the cycle after an accept (DECODE entry).
- zero_flag, instr_count: change at the edge ending WB, visible in the following IDLE cycle.
- rf_we: registered/decoded from state, glitch-free, high exactly one cycle per instruction.

## Configuration
- Macro ZERO_FLAG_EN.
- Defined: at the edge ending WB, zero_flag <= (alu_result == 4'b0000); holds value otherwise.
- Undefined: no flag register built; zero_flag tied to 0 constantly; alu_result unused.
- All other behaviour identical in both builds.

## Test plan
- Reset: rst_n=0 for 3 cycles -> instr_ready=1, busy=0, rf_we=0, alu_sel=00, instr_count=0, zero_flag=0.
- Single op: instr=8'b01_10_01_00 (sub, rd=2, rs1=1, rs2=0) accepted at edge N -> alu_sel=01, rs1_addr=1, rs2_addr=0 from N+1; rf_we=1 with rd_addr=2 only in N+3; instr_count=1 in N+4.
- Back-to-back: instr_valid held 1 with ops add, and, or -> accepts every 4 cycles, alu_sel sequence 00, 10, 11, exactly three rf_we pulses, instr_count=3.
- Zero flag (ZERO_FLAG_EN defined): alu_result=4'h0 during WB -> zero_flag=1; next op with alu_result=4'h5 -> zero_flag=0. Undefined build: zero_flag stays 0 throughout.
- Reset mid-op: assert rst_n=0 during EXEC -> rf_we never pulses, instr_count unchanged at 0, instr_ready=1 immediately.
- Counter wrap: retire 256 instructions -> instr_count returns to 0 after the 256th WB; valid while busy is ignored (instr changed during EXEC has no effect on alu_sel).
